// File: rtl/arm_multicycle_control.sv
// ---------------------------------------------------------------------------
// arm_multicycle_control
//
// Multicycle control unit for the ARM core. Sequences the datapath through
// Fetch/Decode/Execute/Memory/Writeback. It also owns the NZCV flags register
// and the conditional-execution decision for each instruction.
//
// Ports
//   clk         rising-edge system clock
//   rst_n       synchronous active-low reset
//   Instr       IR bits [31:12]: {cond[3:0], op[1:0], I, cmd[3:0], S/L, Rn, Rd}
//   ALUFlags    {N,Z,C,V} produced by the ALU this cycle
//   PCWrite     PC load enable
//   IRWrite     instruction register load enable
//   RegWrite    register bank write enable (WE3)
//   MemWrite    data memory write enable
//   AdrSrc      memory address select: 0=PC, 1=ALU result
//   ResultSrc   00=ALUOut reg, 01=memory data, 10=ALU result
//   ALUSrcA     0=RD1, 1=PC
//   ALUSrcB     00=RD2, 01=ExtImm, 10=constant 4
//   ALUControl  00=ADD, 01=SUB, 10=AND, 11=ORR
//   RegSrc      [0]: read R15 as Rn, [1]: read Rd as ADDR2
//   ImmSrc      00=8-bit DP imm, 01=12-bit offset, 10=24-bit branch
//   state_o     current state, for debug
//
// Handshake: none. Every output is a Moore decode of the state register
// (plus the latched condition bit and the held instruction bits); the four
// write enables are additionally gated low while rst_n is low.
// ---------------------------------------------------------------------------
module arm_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUControl,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ImmSrc,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_EXECI    = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_BRANCH   = STATE_W'(9)
  } state_t;

  // Instruction fields
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic       w_imm;
  logic [3:0] w_cmd;
  logic       w_sl;
  logic [3:0] w_rd;
  logic [3:0] w_unused_rn;

  assign w_cond      = Instr[19:16];
  assign w_op        = Instr[15:14];
  assign w_imm       = Instr[13];
  assign w_cmd       = Instr[12:9];
  assign w_sl        = Instr[8];
  assign w_unused_rn = Instr[7:4];
  assign w_rd        = Instr[3:0];

  // Registered state
  state_t     r_state;
  logic       r_cond;
  logic [3:0] r_flags;

  // Registered outputs (write enables kept raw, gated by rst_n below)
  logic       r_pc_write, r_ir_write, r_reg_write, r_mem_write, r_adr_src;
  logic       r_alu_src_a;
  logic [1:0] r_result_src, r_alu_src_b, r_alu_control, r_reg_src, r_imm_src;

  // Condition evaluation against the architectural flags register
  logic w_cond_ex;
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ex = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Data-processing command decode. Unrecognised commands behave as a NOP:
  // the ALU still adds, but nothing is written and the flags are untouched.
  logic [1:0] w_dp_alu;
  logic       w_dp_nowrite;
  logic       w_dp_flags_en;
  logic       w_dp_cv_en;

  always_comb begin
    w_dp_alu      = 2'b00;
    w_dp_nowrite  = 1'b1;
    w_dp_flags_en = 1'b0;
    w_dp_cv_en    = 1'b0;
    case (w_cmd)
      4'b0100: begin w_dp_alu = 2'b00; w_dp_nowrite = 1'b0; w_dp_flags_en = 1'b1; w_dp_cv_en = 1'b1; end
      4'b0010: begin w_dp_alu = 2'b01; w_dp_nowrite = 1'b0; w_dp_flags_en = 1'b1; w_dp_cv_en = 1'b1; end
      4'b0000: begin w_dp_alu = 2'b10; w_dp_nowrite = 1'b0; w_dp_flags_en = 1'b1; end
      4'b1100: begin w_dp_alu = 2'b11; w_dp_nowrite = 1'b0; w_dp_flags_en = 1'b1; end
      4'b1010: begin w_dp_alu = 2'b01; w_dp_flags_en = 1'b1; w_dp_cv_en = 1'b1; end
      default: begin w_dp_alu = 2'b00; end
    endcase
  end

  // Next state
  state_t w_state_fsm;
  state_t w_state_nxt;
  logic   w_cond_nxt;

  always_comb begin
    w_state_fsm = S_FETCH;
    case (r_state)
      S_FETCH:   w_state_fsm = S_DECODE;
      S_DECODE: begin
        case (w_op)
          2'b00:   w_state_fsm = w_imm ? S_EXECI : S_EXECR;
          2'b01:   w_state_fsm = S_MEMADR;
          2'b10:   w_state_fsm = S_BRANCH;
          default: w_state_fsm = S_FETCH;
        endcase
      end
      S_MEMADR:  w_state_fsm = w_sl ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_state_fsm = S_MEMWB;
      S_EXECR:   w_state_fsm = S_ALUWB;
      S_EXECI:   w_state_fsm = S_ALUWB;
      default:   w_state_fsm = S_FETCH;  // writebacks, branch and illegal codes
    endcase
  end

  assign w_state_nxt = rst_n ? w_state_fsm : S_FETCH;
  // The condition is frozen at DECODE so an EXEC flag update cannot change
  // whether the same instruction writes back.
  assign w_cond_nxt  = !rst_n ? 1'b0 :
                       (r_state == S_DECODE) ? w_cond_ex : r_cond;

  // Output decode of the next state, registered alongside it
  logic       w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_adr_src;
  logic       w_alu_src_a;
  logic [1:0] w_result_src, w_alu_src_b, w_alu_control, w_reg_src, w_imm_src;
  logic       w_rd_pc;

  assign w_rd_pc = (w_rd == 4'b1111);

  always_comb begin
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_control = 2'b00;
    w_reg_src     = 2'b00;
    w_imm_src     = 2'b00;
    case (w_state_nxt)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
      end
      S_MEMADR: begin
        w_alu_src_b = 2'b01;
        w_imm_src   = 2'b01;
      end
      S_MEMREAD: w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = w_cond_nxt;
        w_pc_write   = w_cond_nxt & w_rd_pc;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = w_cond_nxt;
        w_reg_src   = 2'b10;
      end
      S_EXECR: w_alu_control = w_dp_alu;
      S_EXECI: begin
        w_alu_src_b   = 2'b01;
        w_alu_control = w_dp_alu;
      end
      S_ALUWB: begin
        w_reg_write = w_cond_nxt & ~w_dp_nowrite;
        w_pc_write  = w_cond_nxt & ~w_dp_nowrite & w_rd_pc;
      end
      S_BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_imm_src    = 2'b10;
        w_reg_src    = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = w_cond_nxt;
      end
      default: ;
    endcase
  end

  logic w_exec_state;
  assign w_exec_state = (r_state == S_EXECR) || (r_state == S_EXECI);

  always_ff @(posedge clk) begin
    r_state       <= w_state_nxt;
    r_cond        <= w_cond_nxt;
    r_pc_write    <= w_pc_write;
    r_ir_write    <= w_ir_write;
    r_reg_write   <= w_reg_write;
    r_mem_write   <= w_mem_write;
    r_adr_src     <= w_adr_src;
    r_result_src  <= w_result_src;
    r_alu_src_a   <= w_alu_src_a;
    r_alu_src_b   <= w_alu_src_b;
    r_alu_control <= w_alu_control;
    r_reg_src     <= w_reg_src;
    r_imm_src     <= w_imm_src;
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_exec_state && w_sl && r_cond && w_dp_flags_en) begin
      r_flags[3:2] <= ALUFlags[3:2];
      // Logical ops leave carry and overflow untouched
      if (w_dp_cv_en) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign PCWrite    = r_pc_write  & rst_n;
  assign IRWrite    = r_ir_write  & rst_n;
  assign RegWrite   = r_reg_write & rst_n;
  assign MemWrite   = r_mem_write & rst_n;
  assign AdrSrc     = r_adr_src;
  assign ResultSrc  = r_result_src;
  assign ALUSrcA    = r_alu_src_a;
  assign ALUSrcB    = r_alu_src_b;
  assign ALUControl = r_alu_control;
  assign RegSrc     = r_reg_src;
  assign ImmSrc     = r_imm_src;
  assign state_o    = r_state;

endmodule
